// File: rtl/wb_regs_pkg.sv
// Shared widths, enable encodings and constants for the write-back register block.
// Imported by the interface, the register file and the top.
package wb_regs_pkg;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;

    typedef logic [RegBus-1:0]     reg_t;
    typedef logic [RegAddrBus-1:0] raddr_t;

    // True when a read must take the in-flight write-back value instead of storage.
    function automatic logic bypass_hit(input logic re, input raddr_t raddr,
                                        input logic we, input raddr_t waddr);
        return (re == ReadEnable) && (we == WriteEnable) &&
               (raddr == waddr) && (raddr != NOPRegAddr);
    endfunction
endpackage

// File: rtl/wb_regs_if.sv
// Write-back / read-port bundle between the pipeline and the register block.
// master drives writes and read requests; slave returns read data and HI/LO/LLbit.
interface wb_regs_if;
    import wb_regs_pkg::*;

    raddr_t wb_wd;
    logic   wb_wreg;
    reg_t   wb_wdata;
    reg_t   wb_hi;
    reg_t   wb_lo;
    logic   wb_whilo;
    logic   wb_LLbit_we;
    logic   wb_LLbit_value;
    logic   flush;
    logic   re1;
    raddr_t raddr1;
    logic   re2;
    raddr_t raddr2;
    reg_t   rdata1;
    reg_t   rdata2;
    reg_t   hi_o;
    reg_t   lo_o;
    logic   LLbit_o;

    modport master (
        output wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush, re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, hi_o, lo_o, LLbit_o
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata, wb_hi, wb_lo, wb_whilo,
               wb_LLbit_we, wb_LLbit_value, flush, re1, raddr1, re2, raddr2,
        output rdata1, rdata2, hi_o, lo_o, LLbit_o
    );
endinterface

// File: rtl/wb_regs_regfile_2r1w.sv
// GPR file, 2 combinational read ports with write-through bypass, 1 write port.
// Write lands 1 cycle later, reads are 0-latency; no backpressure.
module regfile_2r1w
    import wb_regs_pkg::*;
#(
    parameter int NREG      = 32,
    parameter bit RESET_GPR = 1'b0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   we_i,
    input  raddr_t waddr_i,
    input  reg_t   wdata_i,
    input  logic   re1_i,
    input  raddr_t raddr1_i,
    output reg_t   rdata1_o,
    input  logic   re2_i,
    input  raddr_t raddr2_i,
    output reg_t   rdata2_o
);
    reg_t gpr_q [NREG];

    // Entry 0 is never written, so it needs no reset either way.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            if (RESET_GPR) begin
                for (int i = 1; i < NREG; i++) begin
                    gpr_q[i] <= ZeroWord;
                end
            end
        end else if (we_i == WriteEnable && waddr_i != NOPRegAddr) begin
            gpr_q[waddr_i] <= wdata_i;
        end
    end

    function automatic reg_t read_port(input logic re, input raddr_t raddr);
        if (rst == RstEnable || re == ReadDisable || raddr == NOPRegAddr) begin
            return ZeroWord;
        end else if (bypass_hit(re, raddr, we_i, waddr_i)) begin
            return wdata_i;
        end
        return gpr_q[raddr];
    endfunction

    always_comb begin
        rdata1_o = read_port(re1_i, raddr1_i);
        rdata2_o = read_port(re2_i, raddr2_i);
    end
endmodule

// File: rtl/wb_regs.sv
// Write-back register block: GPR file plus registered HI/LO and LLbit.
// GPR/HI/LO/LLbit writes take 1 cycle, GPR reads are combinational; no backpressure.
module wb_regs
    import wb_regs_pkg::*;
#(
    parameter int NREG      = 32,
    parameter bit RESET_GPR = 1'b0
) (
    input  logic clk,
    input  logic rst,
    wb_regs_if.slave bus
);
    reg_t hi_q, hi_d;
    reg_t lo_q, lo_d;
    logic llbit_q, llbit_d;

    regfile_2r1w #(
        .NREG      (NREG),
        .RESET_GPR (RESET_GPR)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we_i     (bus.wb_wreg),
        .waddr_i  (bus.wb_wd),
        .wdata_i  (bus.wb_wdata),
        .re1_i    (bus.re1),
        .raddr1_i (bus.raddr1),
        .rdata1_o (bus.rdata1),
        .re2_i    (bus.re2),
        .raddr2_i (bus.raddr2),
        .rdata2_o (bus.rdata2)
    );

    // Flush outranks an LLbit write so a trapped SC can never leave the link set.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        llbit_d = llbit_q;
        if (bus.wb_whilo == WriteEnable) begin
            hi_d = bus.wb_hi;
            lo_d = bus.wb_lo;
        end
        if (bus.flush) begin
            llbit_d = 1'b0;
        end else if (bus.wb_LLbit_we == WriteEnable) begin
            llbit_d = bus.wb_LLbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            hi_q    <= ZeroWord;
            lo_q    <= ZeroWord;
            llbit_q <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            llbit_q <= llbit_d;
        end
    end

    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.LLbit_o = llbit_q;
endmodule
